// File: rtl/core_mem_pkg.sv
// rtl/core_mem_pkg.sv - shared owner encoding, tag struct and width defaults for the core memory port
package core_mem_pkg;

    localparam int CORE_ADDR_W = 14;
    localparam int CORE_DATA_W = 16;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    typedef struct packed {
        logic valid;
        logic owner;
    } tag_t;

endpackage

// File: rtl/resp_tag_pipe.sv
// rtl/resp_tag_pipe.sv - MEM_LAT-deep {valid, owner} shift register tracking in-flight reads
//
// Ports:
//   clk, reset  clock, synchronous active-high reset (clears every tag)
//   push_tag    tag entering the pipe this cycle (always pushed)
//   inval_if    clears the valid bit of every IF-owned tag already in flight,
//               including the one emerging this cycle; push_tag is not affected
//   out_tag     tag aligned with the memory read data this cycle
module resp_tag_pipe
    import core_mem_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic clk,
    input  logic reset,
    input  tag_t push_tag,
    input  logic inval_if,
    output tag_t out_tag
);

    tag_t pipe      [MEM_LAT];
    tag_t pipe_next [MEM_LAT];

    always_comb begin
        pipe_next[0] = push_tag;
        for (int i = 1; i < MEM_LAT; i++) begin
            pipe_next[i] = pipe[i-1];
            if (inval_if && pipe[i-1].owner == OWN_IF) begin
                pipe_next[i].valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < MEM_LAT; i++) begin
            if (reset) begin
                pipe[i] <= '0;
            end else begin
                pipe[i] <= pipe_next[i];
            end
        end
    end

    // The emerging tag is dropped in the flush cycle itself, not one cycle later.
    always_comb begin
        out_tag = pipe[MEM_LAT-1];
        if (inval_if && pipe[MEM_LAT-1].owner == OWN_IF) begin
            out_tag.valid = 1'b0;
        end
    end

endmodule

// File: rtl/imem_dmem_port_arbiter.sv
// rtl/imem_dmem_port_arbiter.sv - shares one pipelined memory port between fetch and memory stages
//
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   if_req/if_addr                     fetch read request
//   if_gnt/if_rvalid/if_rdata          fetch grant and read response
//   flush_if                           drop all in-flight fetch responses
//   dm_req/dm_we/dm_addr/dm_wdata      data request (read or write)
//   dm_gnt/dm_rvalid/dm_rdata          data grant and read response
//   mem_en/mem_we/mem_addr/mem_wdata   memory drive
//   mem_rdata                          memory read data, MEM_LAT cycles after a read
//   stall_if/stall_dm                  request pending but not granted
module imem_dmem_port_arbiter
    import core_mem_pkg::*;
#(
    parameter int ADDR_W        = CORE_ADDR_W,
    parameter int DATA_W        = CORE_DATA_W,
    parameter int MEM_LAT       = 1,
    parameter int MAX_DM_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              flush_if,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_dm
);

    localparam int STREAK_W = $clog2(MAX_DM_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_STREAK);

    logic [STREAK_W-1:0] streak;
    logic                if_wins;
    tag_t                push_tag;
    tag_t                out_tag;

    // Data side has priority unless fetch has already waited out a full streak.
    always_comb begin
        if_wins  = if_req && (!dm_req || streak == STREAK_MAX);
        if_gnt   = !reset && if_wins;
        dm_gnt   = !reset && dm_req && !if_wins;
        stall_if = if_req && !if_gnt;
        stall_dm = dm_req && !dm_gnt;
    end

    always_ff @(posedge clk) begin
        if (reset || if_gnt || !if_req) begin
            streak <= '0;
        end else if (dm_gnt && streak != STREAK_MAX) begin
            streak <= streak + 1'b1;
        end
    end

    always_comb begin
        mem_en    = if_gnt || dm_gnt;
        mem_we    = dm_gnt && dm_we;
        mem_addr  = dm_gnt ? dm_addr : if_addr;
        mem_wdata = dm_gnt ? dm_wdata : '0;
    end

    always_comb begin
        push_tag.valid = if_gnt || (dm_gnt && !dm_we);
        push_tag.owner = dm_gnt ? OWN_DM : OWN_IF;
    end

    resp_tag_pipe #(
        .MEM_LAT (MEM_LAT)
    ) u_tag_pipe (
        .clk      (clk),
        .reset    (reset),
        .push_tag (push_tag),
        .inval_if (flush_if),
        .out_tag  (out_tag)
    );

    // Responses emerging while reset is held belong to reads that are being dropped.
    always_comb begin
        if_rvalid = !reset && out_tag.valid && out_tag.owner == OWN_IF;
        dm_rvalid = !reset && out_tag.valid && out_tag.owner == OWN_DM;
        if_rdata  = mem_rdata;
        dm_rdata  = mem_rdata;
    end

endmodule

// File: tb/tb_imem_dmem_port_arbiter.sv
// tb/tb_imem_dmem_port_arbiter.sv - randomized and directed check of the memory port arbiter at MEM_LAT 1 and 2
module tb_imem_dmem_port_arbiter;

    localparam int NC   = 4096;
    localparam int MAXS = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [13:0] if_addr;
    logic        flush_if;
    logic        dm_req;
    logic        dm_we;
    logic [13:0] dm_addr;
    logic [15:0] dm_wdata;

    logic [1:0]  o_if_gnt, o_if_rvalid, o_dm_gnt, o_dm_rvalid;
    logic [1:0]  o_mem_en, o_mem_we, o_stall_if, o_stall_dm;
    logic [15:0] o_if_rdata [2];
    logic [15:0] o_dm_rdata [2];
    logic [13:0] o_mem_addr [2];
    logic [15:0] o_mem_wdata [2];
    logic [15:0] m_rdata [2];

    always #5 clk = ~clk;

    imem_dmem_port_arbiter #(.MEM_LAT(1), .MAX_DM_STREAK(MAXS)) u_lat1 (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(o_if_gnt[0]),
        .if_rvalid(o_if_rvalid[0]), .if_rdata(o_if_rdata[0]), .flush_if(flush_if),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(o_dm_gnt[0]), .dm_rvalid(o_dm_rvalid[0]), .dm_rdata(o_dm_rdata[0]),
        .mem_en(o_mem_en[0]), .mem_we(o_mem_we[0]), .mem_addr(o_mem_addr[0]),
        .mem_wdata(o_mem_wdata[0]), .mem_rdata(m_rdata[0]),
        .stall_if(o_stall_if[0]), .stall_dm(o_stall_dm[0])
    );

    imem_dmem_port_arbiter #(.MEM_LAT(2), .MAX_DM_STREAK(MAXS)) u_lat2 (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(o_if_gnt[1]),
        .if_rvalid(o_if_rvalid[1]), .if_rdata(o_if_rdata[1]), .flush_if(flush_if),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(o_dm_gnt[1]), .dm_rvalid(o_dm_rvalid[1]), .dm_rdata(o_dm_rdata[1]),
        .mem_en(o_mem_en[1]), .mem_we(o_mem_we[1]), .mem_addr(o_mem_addr[1]),
        .mem_wdata(o_mem_wdata[1]), .mem_rdata(m_rdata[1]),
        .stall_if(o_stall_if[1]), .stall_dm(o_stall_dm[1])
    );

    // Memories: unwritten word a holds a + 0x100.
    logic [15:0] mem1 [int];
    logic [15:0] mem2 [int];
    logic [15:0] rd2a;

    always @(posedge clk) begin
        if (o_mem_en[0]) begin
            if (o_mem_we[0]) mem1[int'(o_mem_addr[0])] = o_mem_wdata[0];
            else m_rdata[0] <= mem1.exists(int'(o_mem_addr[0])) ?
                               mem1[int'(o_mem_addr[0])] : 16'(o_mem_addr[0]) + 16'h100;
        end
    end

    always @(posedge clk) begin
        if (o_mem_en[1] && o_mem_we[1]) mem2[int'(o_mem_addr[1])] = o_mem_wdata[1];
        if (o_mem_en[1] && !o_mem_we[1])
            rd2a <= mem2.exists(int'(o_mem_addr[1])) ?
                    mem2[int'(o_mem_addr[1])] : 16'(o_mem_addr[1]) + 16'h100;
        else
            rd2a <= 16'h0;
        m_rdata[1] <= rd2a;
    end

    // Reference model state: expected response per latency per cycle.
    int          n_pass  = 0;
    int          n_total = 0;
    int          cyc     = 0;
    int          streak  = 0;
    int          run     = 0;
    int          max_run = 0;
    bit          ev [2][NC];
    bit          eo [2][NC];
    logic [15:0] ed [2][NC];
    logic [15:0] rmem [int];

    function automatic logic [15:0] ref_rd(input logic [13:0] a);
        return rmem.exists(int'(a)) ? rmem[int'(a)] : 16'(a) + 16'h100;
    endfunction

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s lat%0d cyc=%0d observed=%0h expected=%0h", tag, k + 1, cyc, obs, exp);
    endtask

    task automatic step();
        bit g_if, g_dm, rd_if, rd_dm;
        @(negedge clk);
        g_if = !reset && if_req && (!dm_req || streak >= MAXS);
        g_dm = !reset && dm_req && !g_if;
        for (int k = 0; k < 2; k++) begin
            for (int d = cyc; d <= cyc + k + 1; d++) begin
                if (reset) ev[k][d] = 1'b0;
                if (flush_if && d < cyc + k + 1 && eo[k][d] == 1'b0) ev[k][d] = 1'b0;
            end
            chk("if_gnt", k, 32'(o_if_gnt[k]), 32'(g_if));
            chk("dm_gnt", k, 32'(o_dm_gnt[k]), 32'(g_dm));
            chk("stall_if", k, 32'(o_stall_if[k]), 32'(if_req && !g_if));
            chk("stall_dm", k, 32'(o_stall_dm[k]), 32'(dm_req && !g_dm));
            chk("mem_en", k, 32'(o_mem_en[k]), 32'(g_if || g_dm));
            chk("mem_we", k, 32'(o_mem_we[k]), 32'(g_dm && dm_we));
            if (g_if || g_dm) begin
                chk("mem_addr", k, 32'(o_mem_addr[k]), 32'(g_dm ? dm_addr : if_addr));
                chk("mem_wdata", k, 32'(o_mem_wdata[k]), 32'(g_dm ? dm_wdata : 16'h0));
            end
            rd_if = ev[k][cyc] && eo[k][cyc] == 1'b0;
            rd_dm = ev[k][cyc] && eo[k][cyc] == 1'b1;
            chk("if_rvalid", k, 32'(o_if_rvalid[k]), 32'(rd_if));
            chk("dm_rvalid", k, 32'(o_dm_rvalid[k]), 32'(rd_dm));
            if (rd_if) chk("if_rdata", k, 32'(o_if_rdata[k]), 32'(ed[k][cyc]));
            if (rd_dm) chk("dm_rdata", k, 32'(o_dm_rdata[k]), 32'(ed[k][cyc]));
            if (g_if || (g_dm && !dm_we)) begin
                ev[k][cyc + k + 1] = 1'b1;
                eo[k][cyc + k + 1] = g_dm;
                ed[k][cyc + k + 1] = ref_rd(g_dm ? dm_addr : if_addr);
            end
        end
        run = o_stall_if[0] ? run + 1 : 0;
        if (run > max_run) max_run = run;
        @(posedge clk);
        if (g_dm && dm_we) rmem[int'(dm_addr)] = dm_wdata;
        if (reset || g_if || !if_req) streak = 0;
        else if (g_dm && streak < MAXS) streak++;
        cyc++;
        #1;
    endtask

    task automatic idle();
        reset = 0; if_req = 0; flush_if = 0; dm_req = 0; dm_we = 0;
    endtask

    initial begin
        idle();
        if_addr = '0; dm_addr = '0; dm_wdata = '0;
        #1;
        reset = 1; step(); step();
        idle(); step();

        // Fetch only
        for (int i = 0; i < 3; i++) begin
            if_req = 1; if_addr = 14'(i); step();
        end
        idle(); step(); step();

        // Collision
        if_req = 1; if_addr = 14'h5; dm_req = 1; dm_addr = 14'h20; step();
        dm_req = 0; step();
        idle(); step(); step();

        // Starvation
        max_run = 0;
        for (int i = 0; i < 10; i++) begin
            if_req = 1; if_addr = 14'(i + 8); dm_req = 1; dm_addr = 14'(i + 40); step();
        end
        idle(); step(); step();
        chk("stall_if_run", 0, 32'(max_run <= MAXS), 32'd1);

        // Write then read back
        dm_req = 1; dm_we = 1; dm_addr = 14'h3FF; dm_wdata = 16'hBEEF; step();
        dm_we = 0; dm_wdata = 16'h0; step();
        idle(); step(); step();

        // Flush with fetches in flight
        if_req = 1; if_addr = 14'h60; step();
        if_addr = 14'h61; step();
        if_addr = 14'h62; flush_if = 1; step();
        idle(); step(); step(); step();

        // Reset while a data read is in flight
        dm_req = 1; dm_addr = 14'h77; step();
        reset = 1; if_req = 1; step();
        reset = 0; step();
        idle(); step(); step(); step();

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            reset    = ($urandom_range(0, 63) == 0);
            if_req   = ($urandom_range(0, 3) != 0);
            if_addr  = 14'($urandom_range(0, 63));
            flush_if = ($urandom_range(0, 15) == 0);
            dm_req   = ($urandom_range(0, 2) != 0);
            dm_we    = ($urandom_range(0, 3) == 0);
            dm_addr  = 14'($urandom_range(0, 63));
            dm_wdata = 16'($urandom);
            step();
        end
        idle(); step(); step(); step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
